// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobe, 2-flop column sync, press/release debounce, one key_code per press.
// Latency: key_valid fires (DEBOUNCE_CNT+1) ticks after the detecting tick (inclusive) plus 1 clk; no backpressure, consumer must take the pulse.
module keypad_scanner #(
  parameter int CLK_FREQ     = 27000000,
  parameter int SCAN_FREQ    = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TICK_DIV = CLK_FREQ / SCAN_FREQ;
  localparam int TICK_W   = $clog2(TICK_DIV);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_n;
  logic [3:0]        sync1, cols_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [1:0]        row_idx, row_n;
  logic [1:0]        col_idx, col_n;
  logic [3:0]        deb_cnt, deb_n;
  logic [4:0]        deb_inc;
  logic              single_low;
  logic [1:0]        low_col;
  logic [3:0]        held_pat;
  logic              accept;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = 4'd14;
      4'b11_01: code = 4'd0;
      4'b11_10: code = 4'd15;
      default:  code = 4'd13;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 4'h0;
      cols_s <= 4'h0;
    end else begin
      sync1  <= cols;
      cols_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Exactly one column low; anything else (idle or multi-key) is not a candidate press.
  always_comb begin
    single_low = 1'b1;
    low_col    = 2'd0;
    case (cols_s)
      4'b1110: low_col = 2'd0;
      4'b1101: low_col = 2'd1;
      4'b1011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  assign held_pat = ~(4'b0001 << col_idx);
  assign deb_inc  = {1'b0, deb_cnt} + 5'd1;

  always_comb begin
    state_n = state;
    row_n   = row_idx;
    col_n   = col_idx;
    deb_n   = deb_cnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_low) begin
            col_n   = low_col;
            deb_n   = 4'd0;
            state_n = DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cols_s == held_pat) begin
            deb_n = deb_inc[3:0];
            if (deb_inc >= 5'(DEBOUNCE_CNT)) begin
              state_n = HELD;
              accept  = 1'b1;
            end
          end else begin
            state_n = SCAN;
            row_n   = row_idx + 2'd1;
          end
        end
        HELD: begin
          // Only a full release matters here; extra or different keys are ignored.
          if (cols_s == 4'hF) begin
            state_n = RELEASE;
            deb_n   = 4'd1;
          end
        end
        RELEASE: begin
          if (cols_s == 4'hF) begin
            deb_n = deb_inc[3:0];
            if (deb_inc >= 5'(DEBOUNCE_CNT)) begin
              state_n = SCAN;
              row_n   = row_idx + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      col_idx <= 2'd0;
      deb_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      row_idx <= row_n;
      col_idx <= col_n;
      deb_cnt <= deb_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= key_map(row_idx, col_idx);
      end
    end
  end

  assign rows     = ~(4'b0001 << row_idx);
  assign key_held = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: TICK_DIV=10, DEBOUNCE_CNT=3, with a simple keypad model on cols.
// Timing expectations are in clk edges counted from reset release (base).
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_on;
  logic [1:0] key_r;
  logic [3:0] key_mask;

  int cyc      = 0;
  int base     = 0;
  int vld_cnt  = 0;
  int last_vld = -1;
  int v0       = 0;
  int total    = 0;
  int bad      = 0;

  keypad_scanner #(
    .CLK_FREQ    (100),
    .SCAN_FREQ   (10),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cols     (cols),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid) begin
      vld_cnt  <= vld_cnt + 1;
      last_vld <= cyc;
    end
  end

  // Keypad: pressed switches pull their columns low only while their row is driven.
  assign cols = (key_on && rows[key_r] == 1'b0) ? ~key_mask : 4'hF;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    rst      = 1'b1;
    key_on   = 1'b0;
    key_r    = 2'd0;
    key_mask = 4'h0;

    repeat (2) @(negedge clk);
    check("rst_rows", int'(rows), 14);
    check("rst_code", int'(key_code), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);

    // Idle scan: one row step every 10 clk.
    apply_reset();
    v0 = vld_cnt;
    wait_to(5);   check("idle_rows0", int'(rows), 14);
    wait_to(15);  check("idle_rows1", int'(rows), 13);
    wait_to(25);  check("idle_rows2", int'(rows), 11);
    wait_to(35);  check("idle_rows3", int'(rows), 7);
    wait_to(45);  check("idle_rows_wrap", int'(rows), 14);
    wait_to(100);
    check("idle_no_valid", vld_cnt - v0, 0);
    check("idle_code", int'(key_code), 0);
    check("idle_held", int'(key_held), 0);

    // Key '5' held: detected on the tick ending at edge 20, accepted at edge 50.
    key_r = 2'd1; key_mask = 4'b0010; key_on = 1'b1;
    apply_reset();
    v0 = vld_cnt;
    wait_to(80);
    check("k5_valid_edge", last_vld - base, 50);
    check("k5_one_pulse", vld_cnt - v0, 1);
    check("k5_code", int'(key_code), 5);
    check("k5_held", int'(key_held), 1);

    // Key '5' bounced for 2 ticks only: back to SCAN, row advances to row2.
    apply_reset();
    v0 = vld_cnt;
    wait_to(32); key_on = 1'b0;
    wait_to(45);
    check("short_rows", int'(rows), 11);
    check("short_held", int'(key_held), 0);
    wait_to(100);
    check("short_no_valid", vld_cnt - v0, 0);

    // Key '#' with a one-tick release glitch, clean release, then pressed again.
    key_r = 2'd3; key_mask = 4'b0100; key_on = 1'b1;
    apply_reset();
    v0 = vld_cnt;
    wait_to(100);
    check("hash_valid_edge", last_vld - base, 70);
    check("hash_code", int'(key_code), 15);
    wait_to(152); key_on = 1'b0;
    wait_to(162); key_on = 1'b1;
    wait_to(165);
    check("glitch_held", int'(key_held), 1);
    wait_to(300);
    check("glitch_one_pulse", vld_cnt - v0, 1);
    check("glitch_held_late", int'(key_held), 1);
    key_on = 1'b0;
    wait_to(325);
    check("release_mid_held", int'(key_held), 1);
    wait_to(335);
    check("release_done_held", int'(key_held), 0);
    check("release_rows", int'(rows), 14);
    key_on = 1'b1;
    wait_to(420);
    check("hash2_valid_edge", last_vld - base, 400);
    check("hash2_pulses", vld_cnt - v0, 2);
    check("hash2_code", int'(key_code), 15);

    // Two keys on row0: never accepted, key_code keeps 15.
    key_on = 1'b0;
    wait_to(480);
    check("pre_multi_held", int'(key_held), 0);
    key_r = 2'd0; key_mask = 4'b0011; key_on = 1'b1;
    v0 = vld_cnt;
    wait_to(680);
    check("multi_no_valid", vld_cnt - v0, 0);
    check("multi_code", int'(key_code), 15);
    check("multi_held", int'(key_held), 0);

    // Reset while '5' is held, then fresh detection after release of rst.
    key_r = 2'd1; key_mask = 4'b0010;
    v0 = vld_cnt;
    wait_to(880);
    check("pre_rst_held", int'(key_held), 1);
    check("pre_rst_code", int'(key_code), 5);
    check("pre_rst_pulses", vld_cnt - v0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rows", int'(rows), 14);
    check("async_code", int'(key_code), 0);
    check("async_valid", int'(key_valid), 0);
    check("async_held", int'(key_held), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
    v0   = vld_cnt;
    wait_to(80);
    check("post_rst_valid_edge", last_vld - base, 50);
    check("post_rst_pulses", vld_cnt - v0, 1);
    check("post_rst_code", int'(key_code), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
